// File: rtl/motor_ctrl_pkg.sv
// Shared encodings for the steering command bus and the H-bridge direction pair.
// The tracker stage drives the command; motor_ctrl decodes it.
package motor_ctrl_pkg;

  typedef enum logic [1:0] {
    CMD_STOP        = 2'b00,
    CMD_TURN_RIGHT  = 2'b01,
    CMD_TURN_LEFT   = 2'b10,
    CMD_GO_STRAIGHT = 2'b11
  } cmd_e;

  localparam logic [1:0] DIR_FORWARD = 2'b10;
  localparam logic [1:0] DIR_COAST   = 2'b00;

endpackage

// File: rtl/motor_channel.sv
// One wheel: target decode, per-period duty ramp, registered PWM compare and dir decode.
// The ramp only moves on wrap so each period runs at a single duty.
module motor_channel
  import motor_ctrl_pkg::*;
#(
  parameter int PWM_BITS  = 10,
  parameter int DUTY_FAST = 1000,
  parameter int DUTY_SLOW = 600,
  parameter int STEP      = 50,
  parameter bit IS_LEFT   = 1'b1
) (
  input  logic                clk,
  input  logic                reset,
  input  logic [PWM_BITS-1:0] cnt,
  input  logic                wrap,
  input  logic                stop,
  input  cmd_e                cmd,
  output logic                pwm,
  output logic [1:0]          dir,
  output logic [PWM_BITS-1:0] duty
);

  localparam int W = PWM_BITS + 1;
  localparam logic [W-1:0] FAST_W = W'(DUTY_FAST);
  localparam logic [W-1:0] SLOW_W = W'(DUTY_SLOW);
  localparam logic [W-1:0] STEP_W = W'(STEP);

  logic [W-1:0] target, cur_w, up, dn, nxt;

  always_comb begin
    target = '0;
    case (cmd)
      CMD_STOP:        target = '0;
      CMD_TURN_RIGHT:  target = IS_LEFT ? FAST_W : SLOW_W;
      CMD_TURN_LEFT:   target = IS_LEFT ? SLOW_W : FAST_W;
      CMD_GO_STRAIGHT: target = FAST_W;
      default:         target = '0;
    endcase
  end

  // Extra bit keeps cur+STEP from wrapping; the down path is only taken when cur > target.
  always_comb begin
    cur_w = {1'b0, duty};
    up    = cur_w + STEP_W;
    dn    = ((cur_w - target) > STEP_W) ? (cur_w - STEP_W) : target;
    nxt   = cur_w;
    if (cur_w < target)      nxt = (up > target) ? target : up;
    else if (cur_w > target) nxt = dn;
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      duty <= '0;
      pwm  <= 1'b0;
    end else begin
      pwm <= (cnt < duty);
      if (stop)      duty <= '0;
      else if (wrap) duty <= nxt[PWM_BITS-1:0];
    end
  end

  assign dir = (duty != '0) ? DIR_FORWARD : DIR_COAST;

endmodule

// File: rtl/motor_ctrl.sv
// Two-wheel PWM motor controller: free-running period counter, command sampling on wrap,
// and one motor_channel per wheel. A stop command clears both duties immediately.
module motor_ctrl
  import motor_ctrl_pkg::*;
#(
  parameter int PWM_BITS  = 10,
  parameter int DUTY_FAST = 1000,
  parameter int DUTY_SLOW = 600,
  parameter int STEP      = 50
) (
  input  logic                clk,
  input  logic                reset,
  input  logic [1:0]          state,
  output logic                left_pwm,
  output logic                right_pwm,
  output logic [1:0]          left_dir,
  output logic [1:0]          right_dir,
  output logic [PWM_BITS-1:0] left_duty,
  output logic [PWM_BITS-1:0] right_duty
);

  logic [PWM_BITS-1:0] cnt;
  cmd_e                cmd_q, cmd_eff;
  logic                wrap, stop;

  assign wrap = &cnt;
  assign stop = (state == CMD_STOP);

  always_ff @(posedge clk) begin
    if (!reset) begin
      cnt   <= '0;
      cmd_q <= CMD_STOP;
    end else begin
      cnt <= cnt + 1'b1;
      if (wrap) cmd_q <= cmd_e'(state);
    end
  end

  // The live command is what gets sampled on the wrap cycle itself.
  assign cmd_eff = wrap ? cmd_e'(state) : cmd_q;

  motor_channel #(
    .PWM_BITS(PWM_BITS), .DUTY_FAST(DUTY_FAST), .DUTY_SLOW(DUTY_SLOW),
    .STEP(STEP), .IS_LEFT(1'b1)
  ) u_left (
    .clk(clk), .reset(reset), .cnt(cnt), .wrap(wrap), .stop(stop), .cmd(cmd_eff),
    .pwm(left_pwm), .dir(left_dir), .duty(left_duty)
  );

  motor_channel #(
    .PWM_BITS(PWM_BITS), .DUTY_FAST(DUTY_FAST), .DUTY_SLOW(DUTY_SLOW),
    .STEP(STEP), .IS_LEFT(1'b0)
  ) u_right (
    .clk(clk), .reset(reset), .cnt(cnt), .wrap(wrap), .stop(stop), .cmd(cmd_eff),
    .pwm(right_pwm), .dir(right_dir), .duty(right_duty)
  );

endmodule

// File: tb/tb_motor_ctrl.sv
// Scoreboard bench for motor_ctrl: the driver advances a per-period reference model and
// queues the expected outputs; a negedge monitor pops and compares them.
module tb_motor_ctrl;

  localparam int PWM_BITS = 10;
  localparam int PERIOD   = 1 << PWM_BITS;
  localparam int FAST     = 1000;
  localparam int SLOW     = 600;
  localparam int STEP     = 50;

  logic                clk = 1'b0;
  logic                reset;
  logic [1:0]          state;
  logic                left_pwm, right_pwm;
  logic [1:0]          left_dir, right_dir;
  logic [PWM_BITS-1:0] left_duty, right_duty;

  motor_ctrl #(
    .PWM_BITS(PWM_BITS), .DUTY_FAST(FAST), .DUTY_SLOW(SLOW), .STEP(STEP)
  ) dut (
    .clk(clk), .reset(reset), .state(state),
    .left_pwm(left_pwm), .right_pwm(right_pwm),
    .left_dir(left_dir), .right_dir(right_dir),
    .left_duty(left_duty), .right_duty(right_duty)
  );

  always #5 clk = ~clk;

  typedef struct {
    int ld, rd, lp, rp, ldir, rdir;
  } exp_t;

  exp_t sb[$];
  exp_t mon_e;
  int   n_tests = 0;
  int   n_fail  = 0;
  int   cyc     = 0;

  // Reference model: position in period, duty per wheel, last pwm level per wheel.
  int m_cnt = 0, m_ld = 0, m_rd = 0, m_lp = 0, m_rp = 0;

  function automatic int tgt(input logic [1:0] st, input bit left);
    case (st)
      2'b01:   return left ? FAST : SLOW;
      2'b10:   return left ? SLOW : FAST;
      2'b11:   return FAST;
      default: return 0;
    endcase
  endfunction

  function automatic int ramp(input int cur, input int t);
    if (cur < t) return (cur + STEP < t) ? cur + STEP : t;
    if (cur > t) return (cur - STEP > t) ? cur - STEP : t;
    return cur;
  endfunction

  task automatic step(input logic [1:0] st, input logic rst);
    exp_t e;
    @(negedge clk);
    #2;
    state = st;
    reset = rst;
    if (!rst) begin
      m_cnt = 0; m_ld = 0; m_rd = 0; m_lp = 0; m_rp = 0;
    end else begin
      m_lp = (m_cnt < m_ld) ? 1 : 0;
      m_rp = (m_cnt < m_rd) ? 1 : 0;
      if (st == 2'b00) begin
        m_ld = 0; m_rd = 0;
      end else if (m_cnt == PERIOD - 1) begin
        m_ld = ramp(m_ld, tgt(st, 1'b1));
        m_rd = ramp(m_rd, tgt(st, 1'b0));
      end
      m_cnt = (m_cnt + 1) % PERIOD;
    end
    e.ld = m_ld; e.rd = m_rd; e.lp = m_lp; e.rp = m_rp;
    e.ldir = (m_ld > 0) ? 2 : 0;
    e.rdir = (m_rd > 0) ? 2 : 0;
    sb.push_back(e);
  endtask

  task automatic run(input logic [1:0] st, input int n);
    repeat (n) step(st, 1'b1);
  endtask

  task automatic run_to_cnt(input logic [1:0] st, input int c);
    for (int i = 0; i < 2 * PERIOD && m_cnt != c; i++) step(st, 1'b1);
  endtask

  always @(negedge clk) begin
    cyc <= cyc + 1;
    if (sb.size() > 0) begin
      mon_e = sb.pop_front();
      n_tests++;
      if (mon_e.ld != int'(left_duty) || mon_e.rd != int'(right_duty) ||
          mon_e.lp != int'(left_pwm)  || mon_e.rp != int'(right_pwm)  ||
          mon_e.ldir != int'(left_dir) || mon_e.rdir != int'(right_dir)) begin
        n_fail++;
        $display("FAIL outputs cyc=%0d got duty=%0d/%0d pwm=%0d/%0d dir=%0d/%0d want duty=%0d/%0d pwm=%0d/%0d dir=%0d/%0d",
                 cyc, left_duty, right_duty, left_pwm, right_pwm, left_dir, right_dir,
                 mon_e.ld, mon_e.rd, mon_e.lp, mon_e.rp, mon_e.ldir, mon_e.rdir);
      end
    end
  end

  initial begin
    reset = 1'b0;
    state = 2'b00;
    // Reset held, then idle in stop for three periods.
    repeat (5) step(2'b00, 1'b0);
    run(2'b00, 3 * PERIOD);
    // Straight from rest ramps to full, then turn left drops the left wheel to slow.
    run(2'b11, 21 * PERIOD);
    run(2'b10, 9 * PERIOD);
    // Emergency stop mid-ramp at duty 400, counter 300.
    step(2'b00, 1'b1);
    for (int i = 0; i < 12 * PERIOD && !(m_ld == 400 && m_cnt == 300); i++) step(2'b11, 1'b1);
    step(2'b00, 1'b1);
    run(2'b00, 5);
    // Command toggles inside one period; only the value at wrap counts.
    run_to_cnt(2'b00, 0);
    run(2'b01, 300);
    run(2'b10, 300);
    run(2'b01, 426);
    run(2'b01, PERIOD);
    // Reset pulse at duty 700, then ramp again from zero.
    for (int i = 0; i < 16 * PERIOD && m_ld != 700; i++) step(2'b11, 1'b1);
    step(2'b11, 1'b0);
    run(2'b11, 3 * PERIOD);
    // Random commands with occasional reset pulses.
    for (int k = 0; k < 10; k++) begin
      logic [1:0] st;
      st = 2'($urandom_range(0, 3));
      if ($urandom_range(0, 4) == 0) step(st, 1'b0);
      run(st, $urandom_range(50, 1500));
    end
    @(negedge clk);
    @(negedge clk);
    if (sb.size() != 0) begin
      n_tests++;
      n_fail++;
      $display("FAIL drain got %0d pending want 0", sb.size());
    end
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
